// File: rtl/brq_pkg.sv
// Shared types for the brq data memory responder: response payload and latency bound.
package brq_pkg;

    localparam int unsigned MEM_RSP_MAX_LAT = 8;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } mem_rsp_t;

endpackage

// File: rtl/brq_data_mem_responder_chk.sv
// Property checker for the responder's outstanding-transaction bookkeeping.
module brq_data_mem_responder_chk #(
    parameter int unsigned MaxOutstanding = 2
) (
    input logic       clk_i,
    input logic       rst_ni,
    input logic       data_rvalid_i,
    input logic [3:0] outstanding_i
);

    a_outstanding_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        outstanding_i <= 4'(MaxOutstanding));

    a_rvalid_needs_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        data_rvalid_i |-> (outstanding_i != 4'd0));

endmodule

// File: rtl/brq_mem_rsp_pipe.sv
// Fixed-latency valid/payload shift register carrying memory responses from grant to rvalid.
module brq_mem_rsp_pipe
    import brq_pkg::*;
#(
    parameter int unsigned Latency = 1
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     valid_i,
    input  mem_rsp_t rsp_i,
    output logic     valid_o,
    output mem_rsp_t rsp_o
);

    logic     valid_r [Latency];
    mem_rsp_t rsp_r   [Latency];

    // Shift valid and payload one stage per cycle; reset drops everything in flight
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < Latency; i++) begin
                valid_r[i] <= 1'b0;
                rsp_r[i]   <= {1'b0, 32'h0000_0000};
            end
        end else begin
            valid_r[0] <= valid_i;
            rsp_r[0]   <= rsp_i;
            for (int i = 1; i < Latency; i++) begin
                valid_r[i] <= valid_r[i-1];
                rsp_r[i]   <= rsp_r[i-1];
            end
        end
    end

    assign valid_o = valid_r[Latency-1];
    assign rsp_o   = rsp_r[Latency-1];

endmodule

// File: rtl/brq_data_mem_responder.sv
// Data-side memory responder: word array, address decode, grant logic and outstanding counter.
module brq_data_mem_responder
    import brq_pkg::*;
#(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        stall_i,
    output logic [3:0]  outstanding_o
);

    localparam int unsigned IdxW    = $clog2(MemWords);
    // One bit wider so a window ending at the top of the address space does not wrap
    localparam logic [32:0] EndAddr = {1'b0, BaseAddr} + 33'(MemWords) * 33'd4;

    logic [31:0]     mem_r [MemWords];
    logic [3:0]      outstanding_r;
    logic            in_range_s;
    logic [IdxW-1:0] word_idx_s;
    logic            rsp_valid_s;
    mem_rsp_t        rsp_in_s;
    mem_rsp_t        rsp_out_s;

    // Decode the address window and the word index inside it
    always_comb begin
        in_range_s = ({1'b0, data_addr_i} >= {1'b0, BaseAddr}) && ({1'b0, data_addr_i} < EndAddr);
        word_idx_s = IdxW'((data_addr_i - BaseAddr) >> 2);
    end

    // Grant when not stalled and a slot is free or one retires this cycle
    always_comb begin
        data_gnt_o = data_req_i & ~stall_i & rst_ni &
                     ((outstanding_r < 4'(MaxOutstanding)) | rsp_valid_s);
    end

    // Build the response pushed into the pipe; idle cycles carry a zero payload
    always_comb begin
        rsp_in_s.err   = 1'b0;
        rsp_in_s.rdata = 32'h0000_0000;
        if (data_gnt_o) begin
            rsp_in_s.err   = ~in_range_s;
            rsp_in_s.rdata = (data_we_i | ~in_range_s) ? 32'h0000_0000 : mem_r[word_idx_s];
        end else begin
            rsp_in_s.err   = 1'b0;
            rsp_in_s.rdata = 32'h0000_0000;
        end
    end

    // Byte-lane store on a granted in-range write; contents are never reset
    always_ff @(posedge clk_i) begin
        if (data_gnt_o && data_we_i && in_range_s) begin
            for (int i = 0; i < 4; i++) begin
                if (data_be_i[i]) begin
                    mem_r[word_idx_s][8*i +: 8] <= data_wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Outstanding count: +1 per grant, -1 per retire, unchanged when both coincide
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            outstanding_r <= 4'd0;
        end else begin
            case ({data_gnt_o, rsp_valid_s})
                2'b10:   outstanding_r <= outstanding_r + 4'd1;
                2'b01:   outstanding_r <= outstanding_r - 4'd1;
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    brq_mem_rsp_pipe #(
        .Latency (RespLatency)
    ) u_rsp_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (data_gnt_o),
        .rsp_i   (rsp_in_s),
        .valid_o (rsp_valid_s),
        .rsp_o   (rsp_out_s)
    );

    brq_data_mem_responder_chk #(
        .MaxOutstanding (MaxOutstanding)
    ) u_chk (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .data_rvalid_i (rsp_valid_s),
        .outstanding_i (outstanding_r)
    );

    assign data_rvalid_o = rsp_valid_s;
    assign data_rdata_o  = rsp_out_s.rdata;
    assign data_err_o    = rsp_out_s.err;
    assign outstanding_o = outstanding_r;

endmodule

// File: tb/tb_brq_data_mem_responder.sv
// Directed plus randomized bench for brq_data_mem_responder against a queue-based reference model.
module tb_brq_data_mem_responder;

    localparam int          LAT  = 3;
    localparam int          MAXO = 2;
    localparam int          MEMW = 1024;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        stall_i;
    logic [3:0]  outstanding_o;

    always #5 clk_i = ~clk_i;

    brq_data_mem_responder #(
        .MemWords       (MEMW),
        .BaseAddr       (BASE),
        .RespLatency    (LAT),
        .MaxOutstanding (MAXO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .data_req_i    (data_req_i),
        .data_gnt_o    (data_gnt_o),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .stall_i       (stall_i),
        .outstanding_o (outstanding_o)
    );

    // Reference model: expected responses with their due cycle, plus a word memory
    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl [MEMW];
    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model
    task automatic cycle(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic stall, input logic rst,
                         output logic gnt_obs, output logic gnt_exp);
        logic  retire;
        logic  inr;
        int    idx;
        exp_t  e;
        data_req_i   = req;
        data_we_i    = we;
        data_be_i    = be;
        data_addr_i  = addr;
        data_wdata_i = wdata;
        stall_i      = stall;
        rst_ni       = rst;
        gnt_exp      = 1'b0;
        @(negedge clk_i);
        gnt_obs = data_gnt_o;
        if (!rst) begin
            chk("gnt_in_reset", {31'b0, data_gnt_o}, 32'd0);
            q.delete();
        end else begin
            retire  = (q.size() != 0) && (q[0].due == cyc);
            gnt_exp = req && !stall && ((q.size() < MAXO) || retire);
            chk("outstanding", {28'b0, outstanding_o}, q.size());
            chk("gnt", {31'b0, data_gnt_o}, {31'b0, gnt_exp});
            chk("rvalid", {31'b0, data_rvalid_o}, {31'b0, retire});
            if (retire) begin
                chk("rdata", data_rdata_o, q[0].rdata);
                chk("err", {31'b0, data_err_o}, {31'b0, q[0].err});
                void'(q.pop_front());
            end
            if (gnt_exp) begin
                inr     = (longint'(addr) >= longint'(BASE)) &&
                          (longint'(addr) < longint'(BASE) + 4 * MEMW);
                idx     = int'(((addr - BASE) >> 2) % MEMW);
                e.due   = cyc + LAT;
                e.err   = !inr;
                e.rdata = (we || !inr) ? 32'h0 : mdl[idx];
                q.push_back(e);
                if (we && inr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) mdl[idx][8*b +: 8] = wdata[8*b +: 8];
                    end
                end
            end
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    // Hold a request until the model says it is granted (bounded)
    task automatic xfer(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata);
        logic g;
        logic ge;
        int   n = 0;
        do begin
            cycle(1'b1, we, be, addr, wdata, 1'b0, 1'b1, g, ge);
            n++;
        end while (!ge && n < 16);
        chk("xfer_gnt", {31'b0, g}, 32'd1);
    endtask

    task automatic idle(input int n);
        logic g;
        logic ge;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, g, ge);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            idle(1);
            n++;
        end
        idle(1);
    endtask

    initial begin
        logic        g;
        logic        ge;
        logic [5:0]  pat;
        logic        r_req;
        logic        r_we;
        logic [3:0]  r_be;
        logic [31:0] r_addr;
        logic [31:0] r_wd;
        logic        held;

        rst_ni = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
        data_addr_i = 32'h0; data_wdata_i = 32'h0; stall_i = 1'b0;
        @(posedge clk_i);
        #1;
        cycle(1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, g, ge);
        cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, g, ge);
        chk("rst_rvalid", {31'b0, data_rvalid_o}, 32'd0);
        chk("rst_rdata", data_rdata_o, 32'd0);
        chk("rst_err", {31'b0, data_err_o}, 32'd0);
        chk("rst_outstanding", {28'b0, outstanding_o}, 32'd0);

        // Preload a small window so every later load has defined data
        for (int i = 0; i < 16; i++) xfer(1'b1, 4'hF, 32'(i) * 32'd4, $urandom);
        drain();

        // Store then immediate load of the same word
        xfer(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        xfer(1'b0, 4'hF, 32'h10, 32'h0);
        drain();

        // Byte enables
        xfer(1'b1, 4'hF, 32'h20, 32'h1122_3344);
        xfer(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
        xfer(1'b0, 4'hF, 32'h20, 32'h0);
        drain();

        // Out-of-range load and store, then word 0 must be unchanged
        xfer(1'b0, 4'hF, 32'h0000_1000, 32'h0);
        xfer(1'b1, 4'hF, 32'h0000_1000, 32'hCAFE_F00D);
        xfer(1'b0, 4'hF, 32'h0000_0000, 32'h0);
        drain();

        // Outstanding limit with the request held for six cycles
        pat = 6'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b1, g, ge);
            pat[5-i] = g;
        end
        chk("limit_pattern", {26'b0, pat}, {26'b0, 6'b110110});
        drain();

        // Backpressure: no grant while stalled, grant on release
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1, 1'b1, g, ge);
        cycle(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 1'b1, g, ge);
        chk("stall_release", {31'b0, g}, 32'd1);
        drain();

        // Reset in the middle of two in-flight loads
        xfer(1'b0, 4'hF, 32'h10, 32'h0);
        xfer(1'b0, 4'hF, 32'h20, 32'h0);
        cycle(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b0, g, ge);
        chk("post_rst_outstanding", {28'b0, outstanding_o}, 32'd0);
        idle(LAT + 2);
        xfer(1'b0, 4'hF, 32'h10, 32'h0);
        drain();

        // Randomized traffic; an ungranted request is held stable
        held = 1'b0; r_req = 1'b0; r_we = 1'b0; r_be = 4'h0; r_addr = 32'h0; r_wd = 32'h0;
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                r_req = ($urandom_range(0, 3) != 0);
                r_we  = 1'($urandom_range(0, 1));
                r_be  = 4'($urandom);
                r_wd  = $urandom;
                case ($urandom_range(0, 9))
                    0:       r_addr = 32'h0000_1000 + 32'($urandom_range(0, 255)) * 32'd4;
                    1:       r_addr = 32'hFFFF_FFFC;
                    default: r_addr = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
                endcase
            end
            cycle(r_req, r_we, r_be, r_addr, r_wd, ($urandom_range(0, 4) == 0), 1'b1, g, ge);
            held = r_req && !ge;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
